// File: rtl/csc_stream_ctrl_pkg.sv
// Shared constants for the colour-space stream controller: default converter
// latency, component widths and sideband bit positions.
package csc_stream_ctrl_pkg;

    localparam int CSC_LAT_DEF = 4;
    localparam int PIX_W       = 8;
    localparam int CSC_IN_W    = 9;

    localparam int USER_SOF = 0;
    localparam int USER_EOL = 1;

    typedef logic [PIX_W-1:0]           pix_t;
    typedef logic signed [CSC_IN_W-1:0] csc_in_t;

endpackage

// File: rtl/RGB2YCBCR.sv
// Non-stallable BT.601 RGB to YCbCr converter (studio range).
// Output changes exactly STAGES clocks after the input changes; STAGES >= 3.
module RGB2YCBCR
    import csc_stream_ctrl_pkg::*;
#(
    parameter int STAGES = CSC_LAT_DEF
) (
    input  logic    clk,
    input  csc_in_t r,
    input  csc_in_t g,
    input  csc_in_t b,
    output pix_t    y,
    output pix_t    cb,
    output pix_t    cr
);

    localparam logic signed [8:0] C_YR  = 9'sd66;
    localparam logic signed [8:0] C_YG  = 9'sd129;
    localparam logic signed [8:0] C_YB  = 9'sd25;
    localparam logic signed [8:0] C_BR  = -9'sd38;
    localparam logic signed [8:0] C_BG  = -9'sd74;
    localparam logic signed [8:0] C_BB  = 9'sd112;
    localparam logic signed [8:0] C_RR  = 9'sd112;
    localparam logic signed [8:0] C_RG  = -9'sd94;
    localparam logic signed [8:0] C_RB  = -9'sd18;

    // Round to nearest (floor of x+0.5), add the channel offset, clamp to 8 bits.
    function automatic pix_t rnd_sat(input logic signed [19:0] s, input logic signed [9:0] off);
        logic signed [19:0] t;
        t = ((s + 20'sd128) >>> 8) + 20'(off);
        if (t < 20'sd0)
            return 8'd0;
        else if (t > 20'sd255)
            return 8'd255;
        else
            return t[7:0];
    endfunction

    logic signed [17:0] prod_p0 [0:8];
    logic signed [19:0] sum_p1  [0:2];
    logic [23:0]        res_p2  [0:STAGES-3];

    always_ff @(posedge clk) begin
        // stage 0: coefficient products
        prod_p0[0] <= 18'(r) * 18'(C_YR);
        prod_p0[1] <= 18'(g) * 18'(C_YG);
        prod_p0[2] <= 18'(b) * 18'(C_YB);
        prod_p0[3] <= 18'(r) * 18'(C_BR);
        prod_p0[4] <= 18'(g) * 18'(C_BG);
        prod_p0[5] <= 18'(b) * 18'(C_BB);
        prod_p0[6] <= 18'(r) * 18'(C_RR);
        prod_p0[7] <= 18'(g) * 18'(C_RG);
        prod_p0[8] <= 18'(b) * 18'(C_RB);
        // stage 1: per-channel sums
        sum_p1[0] <= 20'(prod_p0[0]) + 20'(prod_p0[1]) + 20'(prod_p0[2]);
        sum_p1[1] <= 20'(prod_p0[3]) + 20'(prod_p0[4]) + 20'(prod_p0[5]);
        sum_p1[2] <= 20'(prod_p0[6]) + 20'(prod_p0[7]) + 20'(prod_p0[8]);
        // stage 2: rounding, offset, then pure delay to reach STAGES
        res_p2[0] <= {rnd_sat(sum_p1[0], 10'sd16),
                      rnd_sat(sum_p1[1], 10'sd128),
                      rnd_sat(sum_p1[2], 10'sd128)};
        for (int i = 1; i <= STAGES-3; i++)
            res_p2[i] <= res_p2[i-1];
    end

    assign {y, cb, cr} = res_p2[STAGES-3];

endmodule

// File: rtl/csc_stream_ctrl_sfifo_fwft.sv
// Synchronous show-ahead FIFO; a write while full is accepted only if the
// same cycle also pops.
module sfifo_fwft #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic             do_wr;
    logic             do_rd;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rp];

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wp] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr)
                wp <= wp + AW'(1);
            if (do_rd)
                rp <= rp + AW'(1);
            if (do_wr && !do_rd)
                cnt <= cnt + (AW+1)'(1);
            else if (do_rd && !do_wr)
                cnt <= cnt - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/csc_stream_ctrl.sv
// Credit-based flow control around the non-stallable RGB2YCBCR pipeline:
// a pixel is admitted only when a FIFO slot is reserved for its result.
module csc_stream_ctrl
    import csc_stream_ctrl_pkg::*;
#(
    parameter int CSC_LAT    = CSC_LAT_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int USER_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [23:0]       s_rgb,
    input  logic [USER_W-1:0] s_user,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [23:0]       m_ycbcr,
    output logic [USER_W-1:0] m_user,
    output logic              overflow
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int FW    = 3*PIX_W + USER_W;

    logic              accept;
    logic              pop;
    logic              wr;
    logic              full;
    logic              empty;
    logic [OCC_W-1:0]  occ;
    logic [23:0]       rgb_p0;
    logic [CSC_LAT:0]  vld_p0;
    logic [USER_W-1:0] user_p0 [0:CSC_LAT];
    pix_t              y, cb, cr;

    assign s_ready = !rst && (occ != OCC_W'(FIFO_DEPTH));
    assign accept  = s_valid && s_ready;
    assign m_valid = !empty;
    assign pop     = m_valid && m_ready;
    assign wr      = vld_p0[CSC_LAT];

    // Input register and sideband delay line carry data only; no reset needed.
    always_ff @(posedge clk) begin
        if (accept)
            rgb_p0 <= s_rgb;
        user_p0[0] <= s_user;
        for (int i = 1; i <= CSC_LAT; i++)
            user_p0[i] <= user_p0[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            vld_p0 <= {vld_p0[CSC_LAT-1:0], accept};
            if (accept && !pop)
                occ <= occ + OCC_W'(1);
            else if (pop && !accept)
                occ <= occ - OCC_W'(1);
            if (wr && full && !pop)
                overflow <= 1'b1;
        end
    end

    RGB2YCBCR #(
        .STAGES(CSC_LAT)
    ) u_csc (
        .clk(clk),
        .r  ({1'b0, rgb_p0[23:16]}),
        .g  ({1'b0, rgb_p0[15:8]}),
        .b  ({1'b0, rgb_p0[7:0]}),
        .y  (y),
        .cb (cb),
        .cr (cr)
    );

    sfifo_fwft #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr),
        .wr_data({y, cb, cr, user_p0[CSC_LAT]}),
        .rd_en  (pop),
        .rd_data({m_ycbcr, m_user}),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: tb/tb_csc_stream_ctrl.sv
// Randomised bench for csc_stream_ctrl with a queue scoreboard and an
// arithmetic BT.601 reference; a second instance uses an undersized FIFO.
module tb_csc_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, m_valid, m_ready, overflow;
    logic [23:0] s_rgb, m_ycbcr;
    logic [1:0]  s_user, m_user;

    logic        s_valid4, s_ready4, m_valid4, m_ready4, overflow4;
    logic [23:0] s_rgb4, m_ycbcr4;
    logic [1:0]  s_user4, m_user4;

    int n_chk  = 0;
    int n_pass = 0;

    logic [25:0] exp_q[$];
    logic [25:0] exp_q4[$];
    int n_acc = 0, n_out = 0, n_acc4 = 0, n_out4 = 0;

    always #5 clk = ~clk;

    csc_stream_ctrl dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_rgb(s_rgb), .s_user(s_user),
        .m_valid(m_valid), .m_ready(m_ready), .m_ycbcr(m_ycbcr), .m_user(m_user),
        .overflow(overflow)
    );

    csc_stream_ctrl #(.CSC_LAT(4), .FIFO_DEPTH(4), .USER_W(2)) dut4 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid4), .s_ready(s_ready4), .s_rgb(s_rgb4), .s_user(s_user4),
        .m_valid(m_valid4), .m_ready(m_ready4), .m_ycbcr(m_ycbcr4), .m_user(m_user4),
        .overflow(overflow4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // BT.601 studio-range conversion with round-half-up, as plain integer maths.
    function automatic logic [23:0] csc_ref(input logic [23:0] rgb);
        int r, g, b, y, cb, cr;
        r  = int'(rgb[23:16]);
        g  = int'(rgb[15:8]);
        b  = int'(rgb[7:0]);
        y  = ((66*r + 129*g + 25*b + 128) >>> 8) + 16;
        cb = ((-38*r - 74*g + 112*b + 128) >>> 8) + 128;
        cr = ((112*r - 94*g - 18*b + 128) >>> 8) + 128;
        return {y[7:0], cb[7:0], cr[7:0]};
    endfunction

    // Handshakes are settled mid-cycle; observe them on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_q4.delete();
        end else begin
            if (s_valid && s_ready) begin
                exp_q.push_back({csc_ref(s_rgb), s_user});
                n_acc++;
            end
            if (m_valid && m_ready) begin
                n_out++;
                if (exp_q.size() == 0)
                    chk("spurious_out", {6'd0, m_ycbcr, m_user}, 32'hdead);
                else
                    chk("out_pixel", {6'd0, m_ycbcr, m_user}, {6'd0, exp_q.pop_front()});
            end
            if (s_valid4 && s_ready4) begin
                exp_q4.push_back({csc_ref(s_rgb4), s_user4});
                n_acc4++;
            end
            if (m_valid4 && m_ready4) begin
                n_out4++;
                if (exp_q4.size() == 0)
                    chk("spurious_out4", {6'd0, m_ycbcr4, m_user4}, 32'hdead);
                else
                    chk("out_pixel4", {6'd0, m_ycbcr4, m_user4}, {6'd0, exp_q4.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        while ((exp_q.size() != 0 || exp_q4.size() != 0) && cyc < 200) begin
            step();
            cyc++;
        end
        chk(tag, exp_q.size() + exp_q4.size(), 0);
    endtask

    initial begin
        int base_acc, base_out, cyc, mv_cnt;
        logic ok;

        rst = 1'b1;
        s_valid = 1'b0; s_rgb = '0; s_user = '0; m_ready = 1'b1;
        s_valid4 = 1'b0; s_rgb4 = '0; s_user4 = '0; m_ready4 = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_overflow", overflow, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_occ", dut.occ, 0);

        // single pixel latency
        step();
        s_valid = 1'b1; s_rgb = 24'hff0000; s_user = 2'b01;
        @(posedge clk);
        #1 s_valid = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 5 && m_valid) ok = 1'b0;
            if (k == 5) begin
                chk("lat_m_valid", m_valid, 1);
                chk("lat_ycbcr", m_ycbcr, 24'h525af0);
                chk("lat_user", m_user, 2'b01);
            end
        end
        chk("lat_early_valid", ok, 1);
        step();
        drain("single_drain");

        // back-to-back streaming
        base_out = n_out;
        ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            s_valid = 1'b1;
            s_rgb = {8'(i), 8'(255 - i), 8'(i * 3)};
            s_user = 2'(i);
            @(negedge clk);
            if (!s_ready) ok = 1'b0;
            step();
        end
        s_valid = 1'b0;
        chk("stream_ready", ok, 1);
        drain("stream_drain");
        chk("stream_count", n_out - base_out, 64);

        // full backpressure
        m_ready = 1'b0;
        base_acc = n_acc;
        base_out = n_out;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1; s_rgb = $urandom; s_user = 2'($urandom);
            step();
        end
        @(negedge clk);
        chk("bp_accepts", n_acc - base_acc, 8);
        chk("bp_s_ready_low", s_ready, 0);
        step();
        s_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_before_pop", s_ready, 0);
        step();
        @(negedge clk);
        chk("bp_ready_after_pop", s_ready, 1);
        drain("bp_drain");
        chk("bp_count", n_out - base_out, 8);

        // random valid/ready soak
        base_acc = n_acc;
        base_out = n_out;
        cyc = 0;
        while (n_acc - base_acc < 10000 && cyc < 60000) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_rgb   = $urandom;
            s_user  = 2'($urandom);
            m_ready = ($urandom_range(0, 9) < 6);
            step();
            cyc++;
        end
        s_valid = 1'b0; m_ready = 1'b1;
        chk("rand_reached", (n_acc - base_acc) >= 10000, 1);
        drain("rand_drain");
        chk("rand_count", n_out - base_out, n_acc - base_acc);
        chk("rand_overflow", overflow, 0);

        // reset with pixels in flight
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_rgb = $urandom; s_user = 2'($urandom);
            step();
        end
        s_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_occ", dut.occ, 0);
        mv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            if (m_valid) mv_cnt++;
        end
        chk("mid_rst_stale", mv_cnt, 0);

        // undersized FIFO instance
        step();
        m_ready4 = 1'b0;
        base_acc = n_acc4;
        for (int i = 0; i < 12; i++) begin
            s_valid4 = 1'b1; s_rgb4 = $urandom; s_user4 = 2'($urandom);
            step();
        end
        @(negedge clk);
        chk("d4_accepts", n_acc4 - base_acc, 4);
        chk("d4_s_ready_low", s_ready4, 0);
        chk("d4_overflow_bp", overflow4, 0);
        step();
        m_ready4 = 1'b1;
        base_acc = n_acc4;
        for (int i = 0; i < 60; i++) begin
            s_valid4 = 1'b1; s_rgb4 = $urandom; s_user4 = 2'($urandom);
            step();
        end
        s_valid4 = 1'b0;
        chk("d4_rate_below_full", (n_acc4 - base_acc) < 56, 1);
        chk("d4_rate_nonzero", (n_acc4 - base_acc) > 20, 1);
        drain("d4_drain");
        chk("d4_overflow", overflow4, 0);
        chk("final_overflow", overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/csc_stream_ctrl.md
# csc_stream_ctrl

Flow-control wrapper that schedules pixels through the non-stallable `RGB2YCBCR` colour-space pipeline. It sits between the capture front end (RGB pixel stream, valid/ready) and the frame-buffer writer (YCbCr stream, valid/ready). Because the converter cannot be stalled, the block uses credit-based admission: an RGB pixel is accepted only when an output slot is guaranteed. Sideband flags travel aligned with each pixel.

## Interface
Parameters:
- `CSC_LAT`, 4: fixed latency of `RGB2YCBCR` in clocks, from input change to output change.
- `FIFO_DEPTH`, 8: output buffer entries; power of two; ≥ `CSC_LAT`+3 for full rate.
- `USER_W`, 2: sideband width; bit0 = start-of-frame, bit1 = end-of-line.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `s_valid`  in  1  input pixel valid.
- `s_ready`  out  1  input pixel accepted when high with `s_valid`.
- `s_rgb`  in  24  {R,G,B}, 8 bits each, unsigned.
- `s_user`  in  `USER_W`  sideband, sampled with the pixel.
- `m_valid`  out  1  output pixel valid.
- `m_ready`  in  1  downstream accepts.
- `m_ycbcr`  out  24  {Y,Cb,Cr}, 8 bits each.
- `m_user`  out  `USER_W`  sideband aligned to `m_ycbcr`.
- `overflow`  out  1  sticky error: FIFO write while full.

## Operation
- Accept = `s_valid && s_ready`. On accept, load `s_rgb` into the input register. The converter is driven with `{1'b0,R}`, `{1'b0,G}` and `{1'b0,B}` from that register.
- Valid/user shift register, length `CSC_LAT`+1, tracks each accepted pixel.
  - Its tail marks the cycle in which the converter output belongs to that pixel.
  - In that cycle, write {Y,Cb,Cr,user} into the FIFO.
- Occupancy counter `occ` (width clog2(`FIFO_DEPTH`)+1) counts in-flight pixels plus FIFO entries.
  - +1 on accept, −1 on pop; both in the same cycle leaves it unchanged.
  - `s_ready` = !`rst` && `occ` != `FIFO_DEPTH`.
- FIFO is show-ahead. `m_valid` = !empty; pop on `m_valid && m_ready`. Same-cycle write and pop are legal, including when full with a pop.
- Overflow handling: a write while full with no pop drops the pixel and sets `overflow`. This is unreachable under correct `CSC_LAT`. `overflow` is cleared only by `rst`.
- When there is no accept, the input register holds its value. Converter output is ignored because the shift-register valid is 0.
- `m_ycbcr`/`m_user` are don't-care while `m_valid`=0.

## Timing
- Reset values:
  - `s_ready`=0 while `rst`=1, then 1 in the first cycle after `rst` falls.
  - `m_valid`=0, `overflow`=0, `occ`=0.
  - Shift register and FIFO pointers are cleared.
- Reset mid-operation discards all in-flight and buffered pixels. No partial output appears after `rst` falls.
- Latency: a pixel accepted at edge t shows `m_valid`=1 in the cycle after edge t+`CSC_LAT`+1, i.e. `CSC_LAT`+2 cycles (6 at default), provided the FIFO was empty.
- Credit is returned on the edge that pops. `s_ready` can rise in the cycle after a pop from `occ`=`FIFO_DEPTH`.
- Throughput: 1 pixel/clk sustained with `m_ready`=1 when `FIFO_DEPTH` ≥ `CSC_LAT`+3.
- Backpressure: with `m_ready`=0, at most `FIFO_DEPTH` pixels are accepted, then `s_ready`=0 until a pop.
- Ordering: strictly in order. `m_user` is always the `s_user` of the same pixel.

## Structure
- Shared package/header holds:
  - `CSC_LAT` default;
  - pixel component width 8 and converter input width 9;
  - user bit indices `USER_SOF`=0 and `USER_EOL`=1.
- Sub-module `sfifo_fwft`: synchronous show-ahead FIFO. Width 24+`USER_W`, depth `FIFO_DEPTH`, with full/empty flags.
- `RGB2YCBCR` is instantiated directly; there is no local arithmetic.

## Test plan
- Reset then single pixel:
  - After `rst` falls, `s_ready`=1.
  - Send {255,0,0} with user=01.
  - `m_valid` rises exactly 6 cycles later.
  - `m_ycbcr` equals a golden `RGB2YCBCR` instance fed {255,0,0}; `m_user`=01.
- Streaming: 64 back-to-back pixels (counting pattern), `m_ready`=1 → `s_ready` never drops; 64 outputs in order, bit-exact vs golden, with user flags aligned.
- Full backpressure: `m_ready`=0 and `s_valid`=1 continuously → exactly 8 accepts, then `s_ready`=0. Raise `m_ready` → 8 outputs in order, and `s_ready` returns one cycle after the first pop.
- Random ready/valid over 10k pixels → no loss, no duplication, order preserved, `overflow` stays 0.
- Reset mid-stream: assert `rst` for 1 cycle with 5 pixels in flight → `m_valid`=0 the cycle after reset, no stale pixels later, `occ` returns to 0.
- Mis-sized latency: bench forces `FIFO_DEPTH`=4, `CSC_LAT`=4 with `m_ready`=0 → `s_ready` deasserts after 4 accepts and `overflow` stays 0. Throughput with `m_ready`=1 drops below 1 pixel/clk, as expected.
